// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
package if_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] BUBBLE           = 32'b0;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // B-type branch immediate field of an instruction word.
  function automatic logic [11:0] b_imm(input logic [31:0] inst);
    return {inst[31], inst[7], inst[30:25], inst[11:8]};
  endfunction

endpackage

// File: rtl/if_fetch_hold_buf.sv
// One-entry pc/instruction buffer for a word that arrives while the output is stalled.
module fetch_hold_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);
  import if_fetch_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  // Capture on load; drain and clear both empty the entry.
  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    if (clear_i || drain_i) begin
      pc_d   = '0;
      inst_d = BUBBLE;
    end else if (load_i) begin
      pc_d   = pc_i;
      inst_d = inst_i;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q   <= '0;
      inst_q <= '0;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
    end
  end

  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding memory request, stall buffering and branch redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hazard_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [11:0] pcIm_o,
  output logic        valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [11:0]  pcim_q, pcim_d;
  logic         valid_q, valid_d;

  logic         buf_load, buf_drain, buf_clear;
  logic [31:0]  buf_pc, buf_inst;
  logic         slot_free;
  logic         rsp_take;

  assign slot_free = !valid_q || !hazard_i;
  assign rsp_take  = (state_q == ST_WAIT) && imem_valid_i && !drop_q;

  fetch_hold_buf u_hold_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .clear_i (buf_clear),
    .pc_i    (fetch_pc_q),
    .inst_i  (imem_rdata_i),
    .pc_o    (buf_pc),
    .inst_o  (buf_inst)
  );

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      drop_q     <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
      pcim_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pcim_q     <= pcim_d;
      valid_q    <= valid_d;
    end
  end

  // Next state and drop flag; a redirect overrides every other transition.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (flush_i) begin
      unique case (state_q)
        ST_REQ: begin
          // An accepted request now belongs to the old path, so its response must be dropped.
          if (imem_req_o && imem_ready_i) begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_valid_i) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        ST_HOLD: state_d = ST_REQ;
        default: state_d = ST_REQ;
      endcase
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (imem_req_o && imem_ready_i) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_valid_i) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else if (slot_free) begin
              state_d = ST_REQ;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!hazard_i) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  // Memory request, fetch pointer, presented instruction and buffer control.
  always_comb begin
    imem_req_o  = (state_q == ST_REQ) && !rst_i;
    imem_addr_o = fetch_pc_q;
    fetch_pc_d  = fetch_pc_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    pcim_d      = pcim_q;
    valid_d     = valid_q;
    buf_load    = 1'b0;
    buf_drain   = 1'b0;
    buf_clear   = 1'b0;
    if (flush_i) begin
      fetch_pc_d = branch_target_i & 32'hFFFF_FFFC;
      valid_d    = 1'b0;
      inst_d     = BUBBLE;
      pcim_d     = '0;
      buf_clear  = 1'b1;
    end else begin
      // Consumption first; a word loaded below in the same cycle overrides the bubble.
      if (valid_q && !hazard_i) begin
        valid_d = 1'b0;
        inst_d  = BUBBLE;
        pcim_d  = '0;
      end
      if (rsp_take) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        if (slot_free) begin
          pc_d    = fetch_pc_q;
          inst_d  = imem_rdata_i;
          pcim_d  = b_imm(imem_rdata_i);
          valid_d = 1'b1;
        end else begin
          buf_load = 1'b1;
        end
      end else if ((state_q == ST_HOLD) && !hazard_i) begin
        pc_d      = buf_pc;
        inst_d    = buf_inst;
        pcim_d    = b_imm(buf_inst);
        valid_d   = 1'b1;
        buf_drain = 1'b1;
      end
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign pcIm_o  = pcim_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: transaction-level model plus directed literal checks.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        hazard_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_ready_i = 1'b0;
  logic        imem_valid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;

  logic        req0, valid0, req1, valid1;
  logic [31:0] addr0, pc0, inst0, addr1, pc1, inst1;
  logic [11:0] pcim0, pcim1;

  if_fetch dut0 (
    .clk_i(clk), .rst_i(rst_i), .hazard_i(hazard_i), .flush_i(flush_i),
    .branch_target_i(branch_target_i), .imem_req_o(req0), .imem_addr_o(addr0),
    .imem_ready_i(imem_ready_i), .imem_valid_i(imem_valid_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc0), .inst_o(inst0), .pcIm_o(pcim0), .valid_o(valid0)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .hazard_i(hazard_i), .flush_i(flush_i),
    .branch_target_i(branch_target_i), .imem_req_o(req1), .imem_addr_o(addr1),
    .imem_ready_i(imem_ready_i), .imem_valid_i(imem_valid_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc1), .inst_o(inst1), .pcIm_o(pcim1), .valid_o(valid1)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (dut0, RESET_PC = 0) ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  logic [31:0] m_fpc = '0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_inst = '0;
  logic        m_v = 1'b0;
  logic        m_out = 1'b0;
  logic        m_stale = 1'b0;
  ent_t        m_held[$];

  function automatic logic [11:0] imm_of(input logic [31:0] w);
    logic [31:0] r;
    r = (((w >> 31) & 32'h1) << 11) | (((w >> 7) & 32'h1) << 10)
      | (((w >> 25) & 32'h3F) << 4) | ((w >> 8) & 32'hF);
    return r[11:0];
  endfunction

  // Compare dut0 against the model, then advance the model with the inputs the next edge will see.
  always @(negedge clk) begin : cmp_model
    logic m_req, acc, was_v;
    ent_t e;
    m_req = !rst_i && !m_out && (m_held.size() == 0);
    check32("imem_req", {31'b0, req0}, {31'b0, m_req});
    if (m_req) check32("imem_addr", addr0, m_fpc);
    check32("valid", {31'b0, valid0}, {31'b0, m_v});
    check32("pc", pc0, m_pc);
    check32("inst", inst0, m_inst);
    check32("pcIm", {20'b0, pcim0}, {20'b0, imm_of(m_inst)});

    if (rst_i) begin
      m_fpc = '0; m_pc = '0; m_inst = '0; m_v = 1'b0;
      m_out = 1'b0; m_stale = 1'b0; m_held.delete();
    end else begin
      acc   = m_req && imem_ready_i;
      was_v = m_v;
      if (flush_i) begin
        m_fpc  = branch_target_i & 32'hFFFF_FFFC;
        m_v    = 1'b0;
        m_inst = '0;
        m_held.delete();
        if (acc) begin
          m_out = 1'b1; m_stale = 1'b1;
        end else if (m_out) begin
          if (imem_valid_i) begin
            m_out = 1'b0; m_stale = 1'b0;
          end else begin
            m_stale = 1'b1;
          end
        end
      end else begin
        if (m_v && !hazard_i) begin
          m_v = 1'b0; m_inst = '0;
        end
        if (acc) begin
          m_out = 1'b1;
        end else if (m_out && imem_valid_i) begin
          m_out = 1'b0;
          if (m_stale) begin
            m_stale = 1'b0;
          end else begin
            if (!was_v || !hazard_i) begin
              m_pc = m_fpc; m_inst = imem_rdata_i; m_v = 1'b1;
            end else begin
              e.pc = m_fpc; e.w = imem_rdata_i; m_held.push_back(e);
            end
            m_fpc = m_fpc + 32'd4;
          end
        end else if ((m_held.size() != 0) && !hazard_i) begin
          e = m_held.pop_front();
          m_pc = e.pc; m_inst = e.w; m_v = 1'b1;
        end
      end
    end
  end

  // ---------------- memory responder and stimulus ----------------
  logic        rdy = 1'b1;
  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_data = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'hFE00_0EE3;
    return (a * 32'h9E37_79B9) ^ 32'h0000_0033;
  endfunction

  task automatic tick(input logic hz, input logic fl, input logic [31:0] tgt);
    logic acc, drove;
    logic [31:0] a;
    hazard_i = hz;
    flush_i = fl;
    branch_target_i = tgt;
    imem_ready_i = rdy;
    drove = pend && (cnt == 1);
    imem_valid_i = drove;
    imem_rdata_i = drove ? pend_data : 32'hDEAD_BEEF;
    @(negedge clk);
    acc = req0 && imem_ready_i;
    a = addr0;
    @(posedge clk);
    #1;
    if (rst_i) begin
      pend = 1'b0;
    end else begin
      if (drove) pend = 1'b0;
      else if (pend) cnt--;
      if (acc) begin
        pend = 1'b1; cnt = lat; pend_data = mem_word(a);
      end
    end
  endtask

  task automatic wait_req(input string nm, input int lim);
    int k;
    k = 0;
    while (!req0 && k < lim) begin
      tick(1'b0, 1'b0, '0);
      k++;
    end
    check32(nm, {31'b0, req0}, 32'd1);
  endtask

  initial begin
    // Reset and first fetch with 1-cycle memory.
    rdy = 1'b1; lat = 1;
    tick(0, 0, '0);
    tick(0, 0, '0);
    check32("rst_req", {31'b0, req0}, 32'd0);
    check32("rst_valid", {31'b0, valid0}, 32'd0);
    check32("rst_pc", pc0, 32'h0);
    check32("rst_inst", inst0, 32'h0);
    check32("rst_pcim", {20'b0, pcim0}, 32'h0);
    rst_i = 1'b0;
    #1;
    check32("first_req", {31'b0, req0}, 32'd1);
    check32("first_addr", addr0, 32'h0);
    tick(0, 0, '0);
    tick(0, 0, '0);
    check32("f0_pc", pc0, 32'h0);
    check32("f0_inst", inst0, 32'h0000_0013);
    check32("f0_valid", {31'b0, valid0}, 32'd1);
    check32("f1_addr", addr0, 32'h4);

    // Hazard while the second word returns.
    tick(1, 0, '0);
    tick(1, 0, '0);
    tick(1, 0, '0);
    check32("hz_pc", pc0, 32'h0);
    check32("hz_inst", inst0, 32'h0000_0013);
    check32("hz_noreq", {31'b0, req0}, 32'd0);
    tick(0, 0, '0);
    check32("rel_pc", pc0, 32'h4);
    check32("rel_inst", inst0, 32'hFE00_0EE3);
    check32("rel_pcim", {20'b0, pcim0}, 32'h0000_0FFE);
    check32("rel_addr", addr0, 32'h8);

    // Flush while waiting on a slow response.
    lat = 3;
    tick(0, 0, '0);
    tick(0, 1, 32'h0000_0102);
    check32("fl_valid", {31'b0, valid0}, 32'd0);
    wait_req("fl_wait_req", 10);
    check32("fl_addr", addr0, 32'h100);
    check32("fl_valid2", {31'b0, valid0}, 32'd0);
    lat = 1;
    tick(0, 0, '0);
    check32("fl_valid3", {31'b0, valid0}, 32'd0);
    tick(0, 0, '0);
    check32("fl_pc", pc0, 32'h100);
    check32("fl_inst", inst0, mem_word(32'h100));

    // Flush coinciding with the response.
    tick(0, 0, '0);
    tick(0, 1, 32'h0000_0200);
    check32("flv_valid", {31'b0, valid0}, 32'd0);
    check32("flv_addr", addr0, 32'h200);
    tick(0, 0, '0);
    check32("flv_nopulse", {31'b0, valid0}, 32'd0);
    tick(0, 0, '0);
    check32("flv_pc", pc0, 32'h200);

    // Reset during WAIT, both reset vectors.
    lat = 3;
    tick(0, 0, '0);
    tick(0, 0, '0);
    rst_i = 1'b1;
    tick(0, 0, '0);
    check32("rw_valid0", {31'b0, valid0}, 32'd0);
    check32("rw_pc0", pc0, 32'h0);
    check32("rw_req1", {31'b0, req1}, 32'd0);
    check32("rw_pc1", pc1, 32'h0);
    check32("rw_inst1", inst1, 32'h0);
    rst_i = 1'b0;
    #1;
    check32("rw_addr0", addr0, 32'h0);
    check32("rw_addr1", addr1, 32'hFFFF_FFFC);
    lat = 1;
    tick(0, 0, '0);
    tick(0, 0, '0);
    check32("wrap_pc1", pc1, 32'hFFFF_FFFC);
    check32("wrap_valid1", {31'b0, valid1}, 32'd1);
    check32("wrap_addr1", addr1, 32'h0);
    check32("wrap_pcim1", {20'b0, pcim1}, 32'h0);

    // Mixed traffic checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 3);
      rst_i = ($urandom_range(0, 79) == 0);
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom);
    end
    rst_i = 1'b0;
    tick(0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 hazard_i  in  1  downstream stall; the presented instruction is not consumed this cycle.
REQ-005 flush_i  in  1  branch redirect request from the execute stage.
REQ-006 branch_target_i  in  32  redirect address, sampled when flush_i=1.
REQ-007 imem_req_o  out  1  instruction-memory request valid.
REQ-008 imem_addr_o  out  32  request address, word aligned.
REQ-009 imem_ready_i  in  1  memory accepts the request when imem_req_o=1 and imem_ready_i=1.
REQ-010 imem_valid_i  in  1  read data valid, exactly one per accepted request, at least 1 cycle after acceptance.
REQ-011 imem_rdata_i  in  32  instruction word.
REQ-012 pc_o  out  32  address of the presented instruction.
REQ-013 inst_o  out  32  presented instruction; 32'b0 when valid_o=0.
REQ-014 pcIm_o  out  12  B-type immediate {inst[31],inst[7],inst[30:25],inst[11:8]} of inst_o; 12'b0 when valid_o=0.
REQ-015 valid_o  out  1  pc_o, inst_o and pcIm_o carry a real instruction.

Function
REQ-016 States: REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-017 REQ: imem_req_o=1 and imem_addr_o=fetch_pc; on imem_ready_i=1 go to WAIT; imem_req_o=0 in all other states.
REQ-018 WAIT on imem_valid_i=1 with drop flag clear and output slot free (valid_o=0 or hazard_i=0): load pc_o=fetch_pc, inst_o, pcIm_o, set valid_o=1, fetch_pc+=4, go to REQ.
REQ-019 WAIT on imem_valid_i=1 with valid_o=1 and hazard_i=1: store the word and its pc in the hold buffer, fetch_pc+=4, go to HOLD.
REQ-020 HOLD: when hazard_i=0, move the buffer to the outputs with valid_o=1 and go to REQ; otherwise keep all outputs and the buffer unchanged.
REQ-021 Consumption: valid_o=1 and hazard_i=0 with no new word loaded gives valid_o=0, inst_o=0, pcIm_o=0 next cycle; pc_o holds its value.
REQ-022 Response latency: imem_valid_i in cycle N gives the outputs in cycle N+1 and the next imem_req_o in cycle N+1.
REQ-023 Flush has priority over hazard, response and buffer.
REQ-024 On flush_i=1: fetch_pc={branch_target_i[31:2],2'b00}; next cycle valid_o=0, inst_o=0, pcIm_o=0; hold buffer discarded.
REQ-025 Flush in REQ without acceptance: stay in REQ at the new address.
REQ-026 Flush in REQ with acceptance in the same cycle, or flush in WAIT without imem_valid_i: set the drop flag and go to or stay in WAIT.
REQ-027 Flush in WAIT with imem_valid_i in the same cycle: discard the word and go to REQ.
REQ-028 Flush in HOLD: go to REQ.
REQ-029 WAIT on imem_valid_i=1 with drop flag set: discard the word, clear the flag, go to REQ, outputs unchanged.
REQ-030 fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).

Reset
REQ-031 rst_i=1 at any edge, including with a request outstanding: state=REQ, fetch_pc=RESET_PC, drop flag=0, buffer empty, pc_o=0, inst_o=0, pcIm_o=0, valid_o=0.
REQ-032 imem_req_o=0 while rst_i=1; the first request is issued in the first cycle after rst_i falls.
REQ-033 The memory is reset together with this block; no response from before reset is expected afterwards.

Structure
REQ-034 A shared package holds RESET_PC default, state encoding, BUBBLE constant 32'b0 and the B-immediate extraction function.
REQ-035 One sub-module, fetch_hold_buf: one-entry pc/inst buffer with load, drain and clear inputs.

Verification
REQ-036 Reset then imem_ready_i=1, 1-cycle response 32'h0000_0013: imem_addr_o=0, next cycle pc_o=0, inst_o=32'h13, valid_o=1, second request at address 4.
REQ-037 hazard_i=1 for 3 cycles while the response 32'hFE00_0EE3 arrives: outputs keep the prior instruction; on hazard release pc_o=4, inst_o=32'hFE00_0EE3, pcIm_o=12'hFFE.
REQ-038 flush_i=1 with branch_target_i=32'h0000_0102 while in WAIT: stale response dropped, next request address 32'h100, valid_o=0 until it returns.
REQ-039 flush_i and imem_valid_i in the same cycle: word discarded, next request at the target, no valid_o pulse.
REQ-040 rst_i=1 during WAIT: all outputs 0, first request after reset at RESET_PC; repeat with RESET_PC=32'hFFFF_FFFC and check the next fetch is at address 0.
